fifo_credit_sender: RTL and testbench

// - Transmit end of a credit-flow link feeding a remote bsg_fifo_1r1w_small.
// - Accepts words on a ready/valid port and forwards them as valid-only beats.
// - Holds a credit counter preloaded with the remote FIFO depth; the receiver

---
 rtl/fifo_credit_pkg.sv | 14 +
 rtl/fifo_credit_counter.sv | 52 +++++
 rtl/fifo_credit_sender.sv | 56 +++++
 tb/tb_fifo_credit_sender.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_credit_pkg.sv
// Shared types and helpers for the credit-flow link (sender and receiver-side monitor).
package fifo_credit_pkg;

  typedef enum logic {
    CRED_OK  = 1'b0,
    CRED_OVF = 1'b1
  } ovf_cause_e;

  // Counter width able to hold 0..els inclusive.
  function automatic int credit_width(input int els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/fifo_credit_counter.sv
// Saturating credit counter: reset to els_p, up/down strobes, sticky overflow flag.
module fifo_credit_counter
  import fifo_credit_pkg::*;
#(
  parameter int els_p = 4,
  localparam int cw_lp = credit_width(els_p)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             up_i,
  input  logic             down_i,
  output logic [cw_lp-1:0] count_o,
  output logic             overflow_o
);

  localparam logic [cw_lp-1:0] els_lp = cw_lp'(els_p);

  logic [cw_lp-1:0] cnt_r, cnt_n;
  ovf_cause_e       cause_r, cause_n;

  always_comb begin
    cnt_n   = cnt_r;
    cause_n = cause_r;
    case ({up_i, down_i})
      2'b10: begin
        // Returned credit with a full count saturates instead of wrapping.
        if (cnt_r == els_lp) cause_n = CRED_OVF;
        else                 cnt_n   = cnt_r + cw_lp'(1);
      end
      2'b01:   cnt_n = cnt_r - cw_lp'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_r   <= els_lp;
      cause_r <= CRED_OK;
    end else begin
      cnt_r   <= cnt_n;
      cause_r <= cause_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && down_i && !up_i) assert (cnt_r != '0);
  end

  assign count_o    = cnt_r;
  assign overflow_o = (cause_r == CRED_OVF);

endmodule

// File: rtl/fifo_credit_sender.sv
// Transmit side of a credit-flow link into a remote small FIFO.
// Build option: FIFO_CREDIT_SENDER_OUTREG_EN registers the outgoing beat (1-cycle latency).
module fifo_credit_sender
  import fifo_credit_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             v_i,
  output logic                             ready_o,
  input  logic [width_p-1:0]               data_i,
  output logic                             v_o,
  output logic [width_p-1:0]               data_o,
  input  logic                             credit_i,
  output logic [credit_width(els_p)-1:0]   credits_o,
  output logic                             overflow_o
);

  logic acc;

  // Gated by reset so nothing is offered or emitted while the link is being reset.
  assign ready_o = reset_n_i && (credits_o != '0);
  assign acc     = v_i && ready_o;

  fifo_credit_counter #(.els_p(els_p)) counter (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .up_i       (credit_i),
    .down_i     (acc),
    .count_o    (credits_o),
    .overflow_o (overflow_o)
  );

`ifdef FIFO_CREDIT_SENDER_OUTREG_EN
  logic               v_r;
  logic [width_p-1:0] data_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) v_r <= 1'b0;
    else            v_r <= acc;
  end

  always_ff @(posedge clk_i) begin
    if (acc) data_r <= data_i;
  end

  assign v_o    = v_r;
  assign data_o = data_r;
`else
  assign v_o    = acc;
  assign data_o = data_i;
`endif

endmodule

// File: tb/tb_fifo_credit_sender.sv
// Directed and closed-loop bench for fifo_credit_sender (els_p=4, width_p=8).
module tb_fifo_credit_sender;

`ifdef FIFO_CREDIT_SENDER_OUTREG_EN
  localparam bit outreg = 1'b1;
`else
  localparam bit outreg = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       v_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       v_o;
  logic [7:0] data_o;
  logic       credit_i;
  logic [2:0] credits_o;
  logic       overflow_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  fifo_credit_sender #(.width_p(8), .els_p(4)) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .v_i        (v_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .v_o        (v_o),
    .data_o     (data_o),
    .credit_i   (credit_i),
    .credits_o  (credits_o),
    .overflow_o (overflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic edge_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    logic [7:0] rq[$];
    logic [7:0] rx_seq, tx_seq, pend_d, popped, exp_d;
    logic       pend_v, exp_v, exp_ready, acc, v, yumi;
    int         cred_m;

    reset_n_i = 1'b0;
    v_i       = 1'b1;
    data_i    = 8'h00;
    credit_i  = 1'b0;

    // Reset held for 3 cycles with upstream valid asserted
    for (int i = 0; i < 3; i++) edge_step();
    settle();
    chk("rst_credits", credits_o, 4);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_v_o", v_o, 0);
    reset_n_i = 1'b1;
    v_i       = 1'b0;
    settle();
    chk("rel_ready", ready_o, 1);
    chk("rel_credits", credits_o, 4);
    edge_step();

    // Drain all credits
    for (int k = 0; k < 6; k++) begin
      v_i    = 1'b1;
      data_i = 8'(k);
      settle();
      chk($sformatf("drain_credits_%0d", k), credits_o, (k < 4) ? 4 - k : 0);
      chk($sformatf("drain_ready_%0d", k), ready_o, (k < 4) ? 1 : 0);
      exp_v = outreg ? (k >= 1 && k <= 4) : (k < 4);
      chk($sformatf("drain_v_%0d", k), v_o, exp_v);
      if (exp_v) chk($sformatf("drain_data_%0d", k), data_o, outreg ? k - 1 : k);
      edge_step();
    end
    v_i      = 1'b0;
    credit_i = 1'b1;
    settle();
    chk("empty_credits", credits_o, 0);
    chk("empty_ready", ready_o, 0);
    chk("empty_v", v_o, 0);
    edge_step();

    // Simultaneous accept and credit return keeps the count steady
    for (int k = 0; k < 3; k++) begin
      v_i      = 1'b1;
      credit_i = 1'b1;
      data_i   = 8'hA0 + 8'(k);
      settle();
      chk($sformatf("sim_credits_%0d", k), credits_o, 1);
      chk($sformatf("sim_ready_%0d", k), ready_o, 1);
      exp_v = outreg ? (k >= 1) : 1'b1;
      chk($sformatf("sim_v_%0d", k), v_o, exp_v);
      if (exp_v) chk($sformatf("sim_data_%0d", k), data_o, outreg ? 32'hA0 + k - 1 : 32'hA0 + k);
      edge_step();
    end
    v_i      = 1'b0;
    credit_i = 1'b0;
    settle();
    chk("sim_end_credits", credits_o, 1);
    chk("sim_end_v", v_o, outreg ? 1 : 0);
    if (outreg) chk("sim_end_data", data_o, 8'hA2);

    // Refill to full, then return one extra credit
    credit_i = 1'b1;
    for (int i = 0; i < 3; i++) edge_step();
    credit_i = 1'b0;
    settle();
    chk("full_credits", credits_o, 4);
    chk("full_overflow", overflow_o, 0);
    credit_i = 1'b1;
    edge_step();
    credit_i = 1'b0;
    settle();
    chk("ovf_credits", credits_o, 4);
    chk("ovf_flag", overflow_o, 1);
    v_i    = 1'b1;
    data_i = 8'h50;
    edge_step();
    settle();
    chk("ovf_sticky", overflow_o, 1);
    chk("ovf_after_acc_credits", credits_o, 3);

    // Two more accepts bring credits to 1 with the last word still registered
    for (int k = 1; k < 3; k++) begin
      data_i = 8'h50 + 8'(k);
      edge_step();
    end
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    settle();
    chk("mid_credits", credits_o, 1);
    chk("mid_v", v_o, outreg ? 1 : 0);
    edge_step();
    reset_n_i = 1'b1;
    settle();
    chk("mid_rst_v", v_o, 0);
    chk("mid_rst_credits", credits_o, 4);
    chk("mid_rst_overflow", overflow_o, 0);

    // Closed loop against a 4-deep remote FIFO model; yumi returns credits
    cred_m = 4;
    pend_v = 1'b0;
    pend_d = 8'h00;
    rx_seq = 8'h00;
    tx_seq = 8'h00;
    for (int c = 0; c < 300; c++) begin
      v    = 1'($urandom_range(0, 1));
      yumi = (rq.size() != 0) && ($urandom_range(0, 2) != 0);
      v_i      = v;
      credit_i = yumi;
      data_i   = tx_seq;
      settle();
      exp_ready = (cred_m != 0);
      acc       = v && exp_ready;
      exp_v     = outreg ? pend_v : acc;
      exp_d     = outreg ? pend_d : tx_seq;
      chk("cl_ready", ready_o, exp_ready);
      chk("cl_credits", credits_o, cred_m);
      chk("cl_v", v_o, exp_v);
      if (exp_v) chk("cl_data", data_o, exp_d);
      chk("cl_invariant", int'(credits_o) + rq.size() + int'(pend_v), 4);
      chk("cl_overflow", overflow_o, 0);
      if (yumi) begin
        popped = rq.pop_front();
        chk("cl_order", popped, rx_seq);
        rx_seq++;
      end
      if (v_o) rq.push_back(data_o);
      chk("cl_remote_level", rq.size() <= 4, 1);
      pend_v = outreg && acc;
      pend_d = tx_seq;
      if (acc) tx_seq++;
      cred_m = cred_m - int'(acc) + int'(yumi);
      edge_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
